// File: rtl/uart_link_pkg.sv
// Shared definitions for both ends of the UART link: frame constants,
// framer state encoding and the CRC-8 byte update.
package uart_link_pkg;

    localparam logic [7:0] SOF_BYTE = 8'hFF;
    localparam logic [7:0] CRC_POLY = 8'h07;
    localparam logic [7:0] CRC_INIT = 8'h00;

    // Frame byte positions, in transmission order.
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_SOF  = 4'd1,
        ST_A0   = 4'd2,
        ST_A1   = 4'd3,
        ST_A2   = 4'd4,
        ST_A3   = 4'd5,
        ST_D0   = 4'd6,
        ST_D1   = 4'd7,
        ST_D2   = 4'd8,
        ST_D3   = 4'd9,
        ST_CRC  = 4'd10
    } state_e;

    // CRC-8 (MSB-first, no reflection, no final XOR): fold one byte in,
    // one bit per step.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc,
                                             input logic [7:0] data_byte);
        logic [7:0] c;
        c = crc ^ data_byte;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/avmm_uart_framer.sv
// Avalon-MM write slave that turns each accepted write into a 10-byte link
// frame (SOF, 4 address bytes, 4 data bytes, CRC) on an Avalon-ST byte stream.
// A downstream stall lasting STALL_LIMIT cycles abandons the frame.
module avmm_uart_framer
    import uart_link_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        avms_write,
    input  logic [31:0] avms_address,
    input  logic [31:0] avms_writedata,
    output logic        avms_waitrequest,
    output logic [7:0]  avso_data,
    output logic        avso_valid,
    input  logic        avso_ready,
    output logic        tx_busy,
    output logic        tx_abort
);

    localparam int CNT_W = $clog2(STALL_LIMIT + 1);
    // Last stalled count before the abort; the next stalled edge is the limit.
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_LIMIT - 1);

    state_e           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [7:0]       crc_q, crc_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             abort_q, abort_d;

    // Outputs are decoded from registers only; reset gates waitrequest directly.
    assign avms_waitrequest = reset || (state_q != ST_IDLE);
    assign avso_valid       = (state_q != ST_IDLE);
    assign tx_busy          = (state_q != ST_IDLE);
    assign tx_abort         = abort_q;

    // Select the byte presented for the current frame position.
    always_comb begin
        avso_data = 8'h00;
        case (state_q)
            ST_SOF:  avso_data = SOF_BYTE;
            ST_A0:   avso_data = addr_q[7:0];
            ST_A1:   avso_data = addr_q[15:8];
            ST_A2:   avso_data = addr_q[23:16];
            ST_A3:   avso_data = addr_q[31:24];
            ST_D0:   avso_data = data_q[7:0];
            ST_D1:   avso_data = data_q[15:8];
            ST_D2:   avso_data = data_q[23:16];
            ST_D3:   avso_data = data_q[31:24];
            ST_CRC:  avso_data = crc_q;
            default: avso_data = 8'h00;
        endcase
    end

    // Next-state: accept in IDLE, advance on handshake, count stalls toward abort.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        crc_d       = crc_q;
        stall_cnt_d = stall_cnt_q;
        abort_d     = 1'b0;
        if (state_q == ST_IDLE) begin
            stall_cnt_d = '0;
            if (avms_write) begin
                addr_d  = avms_address;
                data_d  = avms_writedata;
                crc_d   = CRC_INIT;
                state_d = ST_SOF;
            end
        end else if (avso_ready) begin
            // A handshake always wins over a stall reaching its limit.
            stall_cnt_d = '0;
            if (state_q >= ST_A0 && state_q <= ST_D3) begin
                crc_d = crc8_next(crc_q, avso_data);
            end
            if (state_q == ST_CRC) begin
                state_d = ST_IDLE;
            end else begin
                state_d = state_e'(state_q + 4'd1);
            end
        end else if (stall_cnt_q == STALL_LAST) begin
            state_d     = ST_IDLE;
            abort_d     = 1'b1;
            stall_cnt_d = '0;
        end else begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            crc_q       <= CRC_INIT;
            stall_cnt_q <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            stall_cnt_q <= stall_cnt_d;
            abort_q     <= abort_d;
        end
    end

    // Captured address/data need no reset; they are only read mid-frame.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_avmm_uart_framer.sv
// Self-checking bench for avmm_uart_framer with randomized frames and a
// frame/CRC reference model based on polynomial division.
module tb_avmm_uart_framer;

    logic        clk = 1'b0;
    logic        reset;
    logic        avms_write;
    logic [31:0] avms_address;
    logic [31:0] avms_writedata;
    logic        avms_waitrequest;
    logic [7:0]  avso_data;
    logic        avso_valid;
    logic        avso_ready;
    logic        tx_busy;
    logic        tx_abort;

    int compared   = 0;
    int mismatched = 0;

    typedef logic [7:0] frame_t [10];

    avmm_uart_framer #(.STALL_LIMIT(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .avms_write       (avms_write),
        .avms_address     (avms_address),
        .avms_writedata   (avms_writedata),
        .avms_waitrequest (avms_waitrequest),
        .avso_data        (avso_data),
        .avso_valid       (avso_valid),
        .avso_ready       (avso_ready),
        .tx_busy          (tx_busy),
        .tx_abort         (tx_abort)
    );

    always #5 clk = ~clk;

    // Reference CRC: remainder of (message * x^8) modulo x^8+x^2+x+1,
    // message = the 8 address/data bytes in wire order, first byte most significant.
    function automatic logic [7:0] ref_crc(input logic [31:0] a, input logic [31:0] d);
        logic [71:0] v;
        v = {a[7:0], a[15:8], a[23:16], a[31:24], d[7:0], d[15:8], d[23:16], d[31:24], 8'h00};
        for (int i = 71; i >= 8; i--) begin
            if (v[i]) v[i -: 9] = v[i -: 9] ^ 9'h107;
        end
        return v[7:0];
    endfunction

    function automatic frame_t ref_frame(input logic [31:0] a, input logic [31:0] d);
        frame_t f;
        f[0] = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            f[1 + i] = a[8*i +: 8];
            f[5 + i] = d[8*i +: 8];
        end
        f[9] = ref_crc(a, d);
        return f;
    endfunction

    // Send one write and collect its frame. mode: 0 ready high, 1 toggling, 2 random.
    task automatic send_frame(input logic [31:0] a, input logic [31:0] d, input int mode,
                              output logic [7:0] crc_byte);
        frame_t exp_f;
        logic [7:0] got [$];
        int cycles;
        logic prev_stall;
        logic [7:0] prev_byte;
        bit stable_ok;
        exp_f = ref_frame(a, d);
        crc_byte = 8'hXX;
        @(negedge clk);
        compared++;
        if (avms_waitrequest !== 1'b0) begin
            mismatched++;
            $display("FAIL accept_ready: waitrequest=%b required 0", avms_waitrequest);
        end
        avms_write = 1'b1; avms_address = a; avms_writedata = d;
        @(posedge clk); #1;
        avms_write = 1'b0;
        cycles = 0; prev_stall = 1'b0; prev_byte = 8'h00; stable_ok = 1'b1;
        while (got.size() < 10 && cycles < 200) begin
            @(negedge clk);
            cycles++;
            case (mode)
                0: avso_ready = 1'b1;
                1: avso_ready = cycles[0];
                default: avso_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (avso_valid !== 1'b1) begin
                mismatched++; compared++;
                $display("FAIL frame_valid: valid=%b required 1 at byte %0d", avso_valid, got.size());
                break;
            end
            if (prev_stall && avso_data !== prev_byte) stable_ok = 1'b0;
            if (avso_ready) got.push_back(avso_data);
            prev_stall = !avso_ready;
            prev_byte  = avso_data;
        end
        avso_ready = 1'b1;
        compared++;
        if (!stable_ok) begin
            mismatched++;
            $display("FAIL data_stable: avso_data changed while ready low (a=%h d=%h)", a, d);
        end
        compared++;
        if (got.size() != 10) begin
            mismatched++;
            $display("FAIL frame_len: got %0d bytes required 10", got.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                compared++;
                if (got[i] !== exp_f[i]) begin
                    mismatched++;
                    $display("FAIL frame_byte%0d: got %h required %h (a=%h d=%h)", i, got[i], exp_f[i], a, d);
                end
            end
            crc_byte = got[9];
        end
        if (mode == 0) begin
            compared++;
            if (cycles != 10) begin
                mismatched++;
                $display("FAIL frame_cycles: took %0d cycles required 10", cycles);
            end
        end
        @(negedge clk);
        compared++;
        if (avso_valid !== 1'b0 || avms_waitrequest !== 1'b0 || tx_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL frame_end_idle: valid=%b wait=%b busy=%b required 0 0 0",
                     avso_valid, avms_waitrequest, tx_busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; avms_write = 1'b0; avms_address = '0; avms_writedata = '0; avso_ready = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if (avso_valid !== 1'b0 || avso_data !== 8'h00 || tx_busy !== 1'b0 ||
            tx_abort !== 1'b0 || avms_waitrequest !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_state: valid=%b data=%h busy=%b abort=%b wait=%b required 0 00 0 0 1",
                     avso_valid, avso_data, tx_busy, tx_abort, avms_waitrequest);
        end
        reset = 1'b0;
        @(negedge clk);
        compared++;
        if (avms_waitrequest !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_release: waitrequest=%b required 0", avms_waitrequest);
        end
    endtask

    task automatic test_known_crc();
        logic [7:0] c;
        send_frame(32'h0, 32'h0, 0, c);
        compared++;
        if (c !== 8'h00) begin mismatched++; $display("FAIL crc_zero: got %h required 00", c); end
        send_frame(32'h0, 32'h01000000, 0, c);
        compared++;
        if (c !== 8'h07) begin mismatched++; $display("FAIL crc_01: got %h required 07", c); end
        send_frame(32'h0, 32'h02000000, 0, c);
        compared++;
        if (c !== 8'h0E) begin mismatched++; $display("FAIL crc_02: got %h required 0E", c); end
    endtask

    task automatic test_toggle_ready();
        logic [7:0] c;
        send_frame(32'h44332211, 32'h88776655, 1, c);
    endtask

    task automatic test_random();
        logic [7:0] c;
        for (int n = 0; n < 12; n++) begin
            send_frame($urandom, $urandom, $urandom_range(0, 2), c);
        end
    endtask

    task automatic test_stall_abort();
        logic [31:0] a, d;
        logic [7:0] c;
        bit ok;
        a = $urandom; d = $urandom;
        @(negedge clk);
        avms_write = 1'b1; avms_address = a; avms_writedata = d; avso_ready = 1'b1;
        @(negedge clk);                       // SOF shown
        avms_write = 1'b0;
        repeat (2) @(negedge clk);            // A0, A1 shown
        @(negedge clk);                       // A2 shown, stall starts
        avso_ready = 1'b0;
        compared++;
        if (avso_valid !== 1'b1 || avso_data !== a[23:16]) begin
            mismatched++;
            $display("FAIL stall_a2: valid=%b data=%h required 1 %h", avso_valid, avso_data, a[23:16]);
        end
        ok = 1'b1;
        for (int s = 2; s <= 16; s++) begin
            @(negedge clk);
            if (avso_valid !== 1'b1 || tx_abort !== 1'b0 || avso_data !== a[23:16]) ok = 1'b0;
        end
        compared++;
        if (!ok) begin mismatched++; $display("FAIL stall_hold: frame dropped or aborted before 16 stall cycles"); end
        @(negedge clk);
        compared++;
        if (tx_abort !== 1'b1 || avso_valid !== 1'b0 || tx_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL stall_abort: abort=%b valid=%b busy=%b required 1 0 0", tx_abort, avso_valid, tx_busy);
        end
        @(negedge clk);
        compared++;
        if (tx_abort !== 1'b0) begin mismatched++; $display("FAIL abort_pulse: abort=%b required 0", tx_abort); end
        avso_ready = 1'b1;
        send_frame($urandom, $urandom, 0, c);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, d1, a2, d2;
        frame_t f1, f2;
        bit ok;
        a1 = $urandom; d1 = $urandom; a2 = $urandom; d2 = $urandom;
        f1 = ref_frame(a1, d1); f2 = ref_frame(a2, d2);
        @(negedge clk);
        avms_write = 1'b1; avms_address = a1; avms_writedata = d1; avso_ready = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin avms_address = a2; avms_writedata = d2; end
            if (avms_waitrequest !== 1'b1 || avso_valid !== 1'b1 || avso_data !== f1[i]) ok = 1'b0;
        end
        compared++;
        if (!ok) begin mismatched++; $display("FAIL b2b_first: first frame wrong or waitrequest low"); end
        @(negedge clk);
        compared++;
        if (avms_waitrequest !== 1'b0 || avso_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_gap: wait=%b valid=%b required 0 0", avms_waitrequest, avso_valid);
        end
        @(negedge clk);
        avms_write = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            if (avso_valid !== 1'b1 || avso_data !== f2[i]) ok = 1'b0;
        end
        compared++;
        if (!ok) begin mismatched++; $display("FAIL b2b_second: second frame wrong or late"); end
        @(negedge clk);
        compared++;
        if (avso_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_end: valid=%b required 0", avso_valid); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] a, d;
        logic [7:0] c;
        a = $urandom; d = $urandom;
        @(negedge clk);
        avms_write = 1'b1; avms_address = a; avms_writedata = d; avso_ready = 1'b1;
        @(negedge clk);
        avms_write = 1'b0;
        repeat (6) @(negedge clk);            // D1 shown
        compared++;
        if (avso_data !== d[15:8]) begin
            mismatched++;
            $display("FAIL rst_mid_d1: data=%h required %h", avso_data, d[15:8]);
        end
        reset = 1'b1;
        @(negedge clk);
        compared++;
        if (avso_valid !== 1'b0 || tx_abort !== 1'b0 || tx_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid: valid=%b abort=%b busy=%b required 0 0 0", avso_valid, tx_abort, tx_busy);
        end
        reset = 1'b0;
        send_frame($urandom, $urandom, 2, c);
    endtask

    initial begin
        test_reset();
        test_known_crc();
        test_toggle_ready();
        test_stall_abort();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
